// File: rtl/operand_fetch_stage.sv
// ID->EX stage: per-operand forwarding (EX > MEM > WB > register file), load-use
// stall detection, bubble insertion, and a saturating stall counter.
module operand_fetch_stage #(
   parameter int DW  = 32,
   parameter int AW  = 5,
   parameter int CW  = 8,
   parameter int SCW = 16
) (
   input  logic           Clk,
   input  logic           Rst,
   input  logic           DecValid,
   input  logic [AW-1:0]  RsAddr,
   input  logic [AW-1:0]  RtAddr,
   input  logic           UseRs,
   input  logic           UseRt,
   input  logic [DW-1:0]  RsData,
   input  logic [DW-1:0]  RtData,
   input  logic [DW-1:0]  DecImm,
   input  logic [AW-1:0]  DecWrAddr,
   input  logic           DecRegWr,
   input  logic           DecMemRead,
   input  logic [CW-1:0]  DecCtrl,
   input  logic           Flush,
   input  logic [DW-1:0]  ExResult,
   input  logic [AW-1:0]  MemWrAddr,
   input  logic           MemRegWr,
   input  logic [DW-1:0]  MemData,
   input  logic [AW-1:0]  WbWrAddr,
   input  logic           WbRegWr,
   input  logic [DW-1:0]  WbData,
   output logic           Stall,
   output logic           ExValid,
   output logic [DW-1:0]  ExRsVal,
   output logic [DW-1:0]  ExRtVal,
   output logic [DW-1:0]  ExImm,
   output logic [AW-1:0]  ExWrAddr,
   output logic           ExRegWr,
   output logic           ExMemRead,
   output logic [CW-1:0]  ExCtrl,
   output logic [SCW-1:0] StallCnt
);

   logic          exFwdEn;
   logic          hazard;
   logic          bubble;
   logic [DW-1:0] rsFwd;
   logic [DW-1:0] rtFwd;

   // A load in ID/EX has no result yet, so it never forwards from EX.
   function automatic logic [DW-1:0] selectOperand(
      input logic [AW-1:0] addr,
      input logic [DW-1:0] rfData,
      input logic          exEn,
      input logic [AW-1:0] exAddr,
      input logic [DW-1:0] exData,
      input logic          memEn,
      input logic [AW-1:0] memAddr,
      input logic [DW-1:0] memData,
      input logic          wbEn,
      input logic [AW-1:0] wbAddr,
      input logic [DW-1:0] wbData
   );
      if (addr == '0)                     return '0;
      else if (exEn && exAddr == addr)    return exData;
      else if (memEn && memAddr == addr)  return memData;
      else if (wbEn && wbAddr == addr)    return wbData;
      else                                return rfData;
   endfunction

   function automatic logic [SCW-1:0] satInc(input logic [SCW-1:0] v);
      return (&v) ? v : v + {{(SCW-1){1'b0}}, 1'b1};
   endfunction

   assign exFwdEn = ExValid & ExRegWr & ~ExMemRead;

   assign rsFwd = selectOperand(RsAddr, RsData, exFwdEn, ExWrAddr, ExResult,
                                MemRegWr, MemWrAddr, MemData, WbRegWr, WbWrAddr, WbData);
   assign rtFwd = selectOperand(RtAddr, RtData, exFwdEn, ExWrAddr, ExResult,
                                MemRegWr, MemWrAddr, MemData, WbRegWr, WbWrAddr, WbData);

   assign hazard = DecValid & ExValid & ExMemRead & (ExWrAddr != '0) &
                   ((UseRs & (RsAddr == ExWrAddr)) | (UseRt & (RtAddr == ExWrAddr)));
   assign Stall  = hazard & ~Flush;
   assign bubble = Flush | Stall | ~DecValid;

   // ID/EX register boundary
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ExValid   <= 1'b0;
         ExRsVal   <= '0;
         ExRtVal   <= '0;
         ExImm     <= '0;
         ExWrAddr  <= '0;
         ExRegWr   <= 1'b0;
         ExMemRead <= 1'b0;
         ExCtrl    <= '0;
         StallCnt  <= '0;
      end else begin
         if (Stall)
            StallCnt <= satInc(StallCnt);
         if (bubble) begin
            ExValid   <= 1'b0;
            ExRegWr   <= 1'b0;
            ExMemRead <= 1'b0;
         end else begin
            ExValid   <= 1'b1;
            ExRsVal   <= rsFwd;
            ExRtVal   <= rtFwd;
            ExImm     <= DecImm;
            ExWrAddr  <= DecWrAddr;
            ExRegWr   <= DecRegWr;
            ExMemRead <= DecMemRead;
            ExCtrl    <= DecCtrl;
         end
      end
   end

endmodule
